// File: rtl/demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// demux_1x2_stream
// Clocked 1-to-2 stream demultiplexer with valid/ready handshakes on all ports.
// Each input beat on x_i is steered to f1 or f2 by s_i, sampled when the beat is
// accepted. Each output owns a one-entry register slice, so a beat is visible one
// cycle after acceptance. A slice can drain and refill on the same edge, which
// keeps one beat per cycle per output.
//
// Optional feature macro: DEMUX_LAST_LOCK_EN
//   When defined, adds x_last_i and a small lock FSM. The route chosen by the
//   first beat of a packet is held until the beat carrying x_last_i, so a packet
//   never splits across outputs. When undefined, every beat uses its own s_i.
// -----------------------------------------------------------------------------
module demux_1x2_stream #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x_i,
   input  logic             x_valid_i,
   output logic             x_ready_o,
   input  logic             s_i,
`ifdef DEMUX_LAST_LOCK_EN
   input  logic             x_last_i,
`endif
   output logic [WIDTH-1:0] f1_o,
   output logic             f1_valid_o,
   input  logic             f1_ready_i,
   output logic [WIDTH-1:0] f2_o,
   output logic             f2_valid_o,
   input  logic             f2_ready_i
);

   logic [WIDTH-1:0] f1Data_q, f1Data_d;
   logic [WIDTH-1:0] f2Data_q, f2Data_d;
   logic             f1Valid_q, f1Valid_d;
   logic             f2Valid_q, f2Valid_d;
   logic             f1Free, f2Free;
   logic             target;
   logic             accept;
   logic             load1, load2;

`ifdef DEMUX_LAST_LOCK_EN
   typedef enum logic {
      LOCK_IDLE,
      LOCK_HELD
   } lockState_e;

   lockState_e lockState_q;
   logic       lockSel_q;

   // Route by s_i between packets, by the latched select inside a packet.
   always_comb begin
      target = s_i;
      if (lockState_q == LOCK_HELD) begin
         target = lockSel_q;
      end
   end

   // Lock FSM: the first non-last beat latches the route, the last beat releases it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lockState_q <= LOCK_IDLE;
         lockSel_q   <= 1'b0;
      end else if (accept) begin
         case (lockState_q)
            LOCK_IDLE: begin
               if (!x_last_i) begin
                  lockState_q <= LOCK_HELD;
                  lockSel_q   <= s_i;
               end
            end
            LOCK_HELD: begin
               if (x_last_i) begin
                  lockState_q <= LOCK_IDLE;
               end
            end
            default: begin
               lockState_q <= LOCK_IDLE;
            end
         endcase
      end
   end
`else
   // Without packet locking every beat is steered by its own select.
   always_comb begin
      target = s_i;
   end
`endif

   // A slice can take a beat when it is empty or is being drained this cycle.
   // Ready is held low during reset and never looks at x_valid_i.
   always_comb begin
      f1Free    = !f1Valid_q || f1_ready_i;
      f2Free    = !f2Valid_q || f2_ready_i;
      x_ready_o = rst_n && (target ? f2Free : f1Free);
      accept    = x_valid_i && x_ready_o;
      load1     = accept && !target;
      load2     = accept && target;
   end

   // Next state of slice 1: load wins over drain so a full slice refills bubble-free.
   always_comb begin
      f1Data_d  = f1Data_q;
      f1Valid_d = f1Valid_q;
      if (load1) begin
         f1Data_d  = x_i;
         f1Valid_d = 1'b1;
      end else if (f1_ready_i) begin
         f1Valid_d = 1'b0;
      end
   end

   // Next state of slice 2, same rules as slice 1 and fully independent of it.
   always_comb begin
      f2Data_d  = f2Data_q;
      f2Valid_d = f2Valid_q;
      if (load2) begin
         f2Data_d  = x_i;
         f2Valid_d = 1'b1;
      end else if (f2_ready_i) begin
         f2Valid_d = 1'b0;
      end
   end

   // Slice registers; reset discards any held beat and clears the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f1Data_q  <= '0;
         f1Valid_q <= 1'b0;
         f2Data_q  <= '0;
         f2Valid_q <= 1'b0;
      end else begin
         f1Data_q  <= f1Data_d;
         f1Valid_q <= f1Valid_d;
         f2Data_q  <= f2Data_d;
         f2Valid_q <= f2Valid_d;
      end
   end

   assign f1_o       = f1Data_q;
   assign f1_valid_o = f1Valid_q;
   assign f2_o       = f2Data_q;
   assign f2_valid_o = f2Valid_q;

endmodule
